// File: rtl/jt12_eg_cfg.sv
// Envelope-generator configuration writer: decodes YM2612 regs 0x28/0x40-0x9F into a 24-slot store
// and replays it slot by slot. Optional readback port enabled by JT12_EGCFG_RDBK_EN.
module jt12_eg_cfg #(
    parameter int unsigned BUSY_CYC = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       wr_req,
    input  logic       wr_part,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       busy,
    output logic       zero,
    output logic [4:0] slot,
    output logic [4:0] arate_II,
    output logic [4:0] rate1_II,
    output logic [4:0] rate2_II,
    output logic [3:0] rrate_II,
    output logic [3:0] d1l,
    output logic [1:0] ks_II,
    output logic [6:0] tl,
    output logic       ssg_en_II,
    output logic [2:0] ssg_eg_II,
    output logic       keyon_II
`ifdef JT12_EGCFG_RDBK_EN
    ,
    input  logic       rd_part,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    localparam int unsigned CW = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYC - 1);

    // Slot index: op*6 + ch, with the register op order S1,S3,S2,S4 mapped to slot order S1,S2,S3,S4.
    function automatic logic [4:0] slot_of(input logic part, input logic [3:0] a);
        logic [4:0] op6;
        case (a[3:2])
            2'd0:    op6 = 5'd0;
            2'd1:    op6 = 5'd12;
            2'd2:    op6 = 5'd6;
            default: op6 = 5'd18;
        endcase
        return op6 + (part ? 5'd3 : 5'd0) + {3'b000, a[1:0]};
    endfunction

    logic [1:0] rst_sync;
    logic       rst_s_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_s_n = rst_sync[1];

    logic [23:0][6:0] tl_m;
    logic [23:0][1:0] ks_m;
    logic [23:0][4:0] ar_m;
    logic [23:0][4:0] d1r_m;
    logic [23:0][4:0] d2r_m;
    logic [23:0][3:0] d1l_m;
    logic [23:0][3:0] rr_m;
    logic [23:0][2:0] ssg_eg_m;
    logic [23:0]      ssg_en_m;
    logic [23:0]      kon_m;

    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic          wr_fire;
    logic [4:0]    wr_slot;
    logic [4:0]    kon_ch;
    logic          kon_hit;
    logic [4:0]    nxt_slot;

    assign wr_fire = clk_en && wr_req && (st == ST_IDLE);
    assign wr_slot = slot_of(wr_part, wr_addr[3:0]);
    assign kon_ch  = (wr_data[2] ? 5'd3 : 5'd0) + {3'b000, wr_data[1:0]};
    assign kon_hit = (wr_addr == 8'h28) && !wr_part && (wr_data[1:0] != 2'd3);

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            wr_ack <= 1'b0;
            busy   <= 1'b0;
        end else if (clk_en) begin
            case (st)
                ST_IDLE: begin
                    if (wr_req) begin
                        st     <= ST_ACK;
                        wr_ack <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    wr_ack <= 1'b0;
                    cnt    <= CNT_LOAD;
                    st     <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        busy <= 1'b0;
                        st   <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            tl_m     <= '0;
            ks_m     <= '0;
            ar_m     <= '0;
            d1r_m    <= '0;
            d2r_m    <= '0;
            d1l_m    <= '0;
            rr_m     <= '0;
            ssg_eg_m <= '0;
            ssg_en_m <= '0;
            kon_m    <= '0;
        end else if (wr_fire) begin
            if (kon_hit) begin
                kon_m[kon_ch]         <= wr_data[4];
                kon_m[kon_ch + 5'd6]  <= wr_data[5];
                kon_m[kon_ch + 5'd12] <= wr_data[6];
                kon_m[kon_ch + 5'd18] <= wr_data[7];
            end else if (wr_addr[1:0] != 2'd3) begin
                case (wr_addr[7:4])
                    4'h4: tl_m[wr_slot] <= wr_data[6:0];
                    4'h5: begin
                        ks_m[wr_slot] <= wr_data[7:6];
                        ar_m[wr_slot] <= wr_data[4:0];
                    end
                    4'h6: d1r_m[wr_slot] <= wr_data[4:0];
                    4'h7: d2r_m[wr_slot] <= wr_data[4:0];
                    4'h8: begin
                        d1l_m[wr_slot] <= wr_data[7:4];
                        rr_m[wr_slot]  <= wr_data[3:0];
                    end
                    4'h9: begin
                        ssg_en_m[wr_slot] <= wr_data[3];
                        ssg_eg_m[wr_slot] <= wr_data[2:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        nxt_slot = (slot == 5'd23) ? '0 : slot + 5'd1;
    end

    // Outputs load the slot being entered; a write on the same edge lands in the store only,
    // so the presented fields are always one coherent snapshot.
    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            slot      <= '0;
            zero      <= 1'b1;
            arate_II  <= '0;
            rate1_II  <= '0;
            rate2_II  <= '0;
            rrate_II  <= '0;
            d1l       <= '0;
            ks_II     <= '0;
            tl        <= '0;
            ssg_en_II <= 1'b0;
            ssg_eg_II <= '0;
            keyon_II  <= 1'b0;
        end else if (clk_en) begin
            slot      <= nxt_slot;
            zero      <= (nxt_slot == '0);
            arate_II  <= ar_m[nxt_slot];
            rate1_II  <= d1r_m[nxt_slot];
            rate2_II  <= d2r_m[nxt_slot];
            rrate_II  <= rr_m[nxt_slot];
            d1l       <= d1l_m[nxt_slot];
            ks_II     <= ks_m[nxt_slot];
            tl        <= tl_m[nxt_slot];
            ssg_en_II <= ssg_en_m[nxt_slot];
            ssg_eg_II <= ssg_eg_m[nxt_slot];
            keyon_II  <= kon_m[nxt_slot];
        end
    end

`ifdef JT12_EGCFG_RDBK_EN
    logic [4:0] rd_slot;

    assign rd_slot = slot_of(rd_part, rd_addr[3:0]);

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            rd_data <= '0;
        end else if (clk_en) begin
            if (rd_addr[1:0] == 2'd3) begin
                rd_data <= '0;
            end else begin
                case (rd_addr[7:4])
                    4'h4:    rd_data <= {1'b0, tl_m[rd_slot]};
                    4'h5:    rd_data <= {ks_m[rd_slot], 1'b0, ar_m[rd_slot]};
                    4'h6:    rd_data <= {3'b000, d1r_m[rd_slot]};
                    4'h7:    rd_data <= {3'b000, d2r_m[rd_slot]};
                    4'h8:    rd_data <= {d1l_m[rd_slot], rr_m[rd_slot]};
                    4'h9:    rd_data <= {4'b0000, ssg_en_m[rd_slot], ssg_eg_m[rd_slot]};
                    default: rd_data <= '0;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_jt12_eg_cfg.sv
// Scoreboard bench for jt12_eg_cfg: directed register writes push expected slot snapshots,
// a monitor pops them when the DUT presents the matching slot.
module tb_jt12_eg_cfg;
    localparam int unsigned BC = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b1;
    logic       wr_req = 1'b0;
    logic       wr_part = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack, busy, zero, ssg_en_II, keyon_II;
    logic [4:0] slot, arate_II, rate1_II, rate2_II;
    logic [3:0] rrate_II, d1l;
    logic [1:0] ks_II;
    logic [6:0] tl;
    logic [2:0] ssg_eg_II;
`ifdef JT12_EGCFG_RDBK_EN
    logic       rd_part = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
`endif

    always #5 clk = ~clk;

    jt12_eg_cfg #(.BUSY_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .wr_req(wr_req), .wr_part(wr_part), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .zero(zero), .slot(slot),
        .arate_II(arate_II), .rate1_II(rate1_II), .rate2_II(rate2_II),
        .rrate_II(rrate_II), .d1l(d1l), .ks_II(ks_II), .tl(tl),
        .ssg_en_II(ssg_en_II), .ssg_eg_II(ssg_eg_II), .keyon_II(keyon_II)
`ifdef JT12_EGCFG_RDBK_EN
        , .rd_part(rd_part), .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    typedef struct {
        string       name;
        int          slot;
        int          min_cyc;
        logic [36:0] exp;
    } cfg_item_t;

    cfg_item_t cq[$];
    int        ack_q[$];
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    bit        track = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic void fail(input string nm, input int act, input int exp);
        total++;
        bad++;
        $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    endfunction

    // {keyon, ssg_en, ssg_eg, tl, ks, ar, d1r, d2r, d1l, rr}
    function automatic logic [36:0] pk(input logic ko, input logic se, input logic [2:0] sg,
                                       input logic [6:0] t, input logic [1:0] k, input logic [4:0] a,
                                       input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [3:0] sl, input logic [3:0] rr);
        return {ko, se, sg, t, k, a, r1, r2, sl, rr};
    endfunction

    function automatic logic [36:0] cfg_now();
        return {keyon_II, ssg_en_II, ssg_eg_II, tl, ks_II, arate_II, rate1_II, rate2_II, d1l, rrate_II};
    endfunction

    function automatic void expect_cfg(input string nm, input int s, input logic [36:0] e);
        cq.push_back('{nm, s, cyc + 1, e});
    endfunction

    // Monitor: slot sequencing, busy length, ack width/spacing, and the config scoreboard.
    int prev_slot = 0;
    int bcnt = 0;
    int aw = 0;
    bit ack_prev = 1'b0;
    int last_ack = 0;

    always @(posedge clk) begin
        bit en_s;
        int g;
        en_s = clk_en;
        #1;
        if (en_s && rst_n) cyc++;
        if (track) begin
            chk("slot_seq", 64'(slot), 64'(en_s ? ((prev_slot == 23) ? 0 : prev_slot + 1) : prev_slot));
            chk("zero_flag", 64'(zero), 64'(slot == 5'd0));
        end
        prev_slot = int'(slot);

        if (!rst_n) begin
            bcnt = 0;
        end else if (busy) begin
            if (en_s) bcnt++;
        end else if (bcnt != 0) begin
            chk("busy_len", 64'(bcnt), 64'(BC + 1));
            bcnt = 0;
        end

        if (wr_ack) begin
            if (!ack_prev) begin
                if (ack_q.size() == 0) begin
                    fail("ack_unexpected", 1, 0);
                end else begin
                    g = ack_q.pop_front();
                    if (g >= 0) chk("ack_gap", 64'(cyc - last_ack), 64'(g));
                end
                last_ack = cyc;
                aw = 0;
            end
            if (en_s) aw++;
        end else if (ack_prev) begin
            chk("ack_width", 64'(aw), 64'(1));
        end
        ack_prev = wr_ack;

        while (cq.size() > 0 && rst_n && cyc >= cq[0].min_cyc && int'(slot) == cq[0].slot) begin
            chk(cq[0].name, 64'(cfg_now()), 64'(cq[0].exp));
            void'(cq.pop_front());
        end
        if (cq.size() > 0 && cyc > cq[0].min_cyc + 100) begin
            fail({cq[0].name, "_timeout"}, cyc, cq[0].min_cyc);
            void'(cq.pop_front());
        end
    end

    task automatic drain();
        int n = 0;
        while (cq.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (cq.size() > 0) begin
            fail("drain", cq.size(), 0);
            cq.delete();
        end
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_ack && n < 100);
        if (!wr_ack) fail({nm, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail({nm, "_busy_timeout"}, 1, 0);
    endtask

    task automatic wait_slot1(input string nm);
        int n = 0;
        while (slot != 5'd1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (slot != 5'd1) fail({nm, "_slot_timeout"}, int'(slot), 1);
    endtask

    task automatic do_write(input logic p, input logic [7:0] a, input logic [7:0] d);
        ack_q.push_back(-1);
        wr_part = p;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        wait_ack("wr");
        wr_req = 1'b0;
        wait_idle("wr");
    endtask

    localparam logic [36:0] Z = '0;

    initial begin
        int  n;
        bit  seen_low;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_cfg", 64'(cfg_now()), 64'(Z));
        chk("rst_slot", 64'(slot), 64'(0));
        chk("rst_zero", 64'(zero), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ack", 64'(wr_ack), 64'(0));
        rst_n = 1'b1;
        wait_slot1("rst");
        track = 1'b1;
        repeat (30) @(negedge clk);

        // part0 0x52=0x9F -> slot 2 ks=2 ar=31
        do_write(1'b0, 8'h52, 8'h9F);
        expect_cfg("t2_slot2", 2, pk(1'b0, 1'b0, 3'd0, 7'd0, 2'd2, 5'd31, 5'd0, 5'd0, 4'd0, 4'd0));
        expect_cfg("t2_slot3", 3, Z);
        expect_cfg("t2_slot8", 8, Z);
        drain();

`ifdef JT12_EGCFG_RDBK_EN
        rd_part = 1'b0;
        rd_addr = 8'h52;
        @(negedge clk);
        chk("rdbk_52", 64'(rd_data), 64'(8'h9F));
        rd_addr = 8'h28;
        @(negedge clk);
        chk("rdbk_28", 64'(rd_data), 64'(8'h00));
`endif

        // part1 0x84=0x5A -> slot 15 d1l=5 rr=10; 0x87 leaves store alone
        do_write(1'b1, 8'h84, 8'h5A);
        expect_cfg("t3_slot15", 15, pk(1'b0, 1'b0, 3'd0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 4'd5, 4'd10));
        drain();
        do_write(1'b1, 8'h87, 8'hFF);
        expect_cfg("t3_87_slot15", 15, pk(1'b0, 1'b0, 3'd0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 4'd5, 4'd10));
        expect_cfg("t3_87_slot21", 21, Z);
        drain();

        // key-on ch4
        do_write(1'b0, 8'h28, 8'hF5);
        expect_cfg("t4_kon4", 4, pk(1'b1, 1'b0, 3'd0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 4'd0, 4'd0));
        expect_cfg("t4_kon10", 10, pk(1'b1, 1'b0, 3'd0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 4'd0, 4'd0));
        expect_cfg("t4_kon16", 16, pk(1'b1, 1'b0, 3'd0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 4'd0, 4'd0));
        expect_cfg("t4_kon22", 22, pk(1'b1, 1'b0, 3'd0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 4'd0, 4'd0));
        expect_cfg("t4_kon3", 3, Z);
        drain();
        do_write(1'b0, 8'h28, 8'h05);
        expect_cfg("t4_koff4", 4, Z);
        expect_cfg("t4_koff22", 22, Z);
        drain();
        do_write(1'b0, 8'h28, 8'hF3);
        expect_cfg("t4_code3_slot3", 3, Z);
        expect_cfg("t4_code3_slot4", 4, Z);
        drain();
        do_write(1'b1, 8'h28, 8'hF0);
        expect_cfg("t4_part1_slot0", 0, Z);
        drain();

        // wr_req held through busy, with clk_en stretches
        ack_q.push_back(-1);
        wr_part = 1'b0;
        wr_addr = 8'h40;
        wr_data = 8'h7F;
        wr_req  = 1'b1;
        wait_ack("t5a");
        ack_q.push_back(2 + BC);
        wr_addr  = 8'h98;
        wr_data  = 8'h0D;
        seen_low = 1'b0;
        n = 0;
        do begin
            clk_en = ((n % 4) != 2);
            @(negedge clk);
            n++;
            if (!wr_ack) seen_low = 1'b1;
        end while (!(seen_low && wr_ack) && n < 400);
        if (!(seen_low && wr_ack)) fail("t5b_ack_timeout", 0, 1);
        wr_req = 1'b0;
        clk_en = 1'b1;
        wait_idle("t5");
        expect_cfg("t5_slot0_tl", 0, pk(1'b0, 1'b0, 3'd0, 7'd127, 2'd0, 5'd0, 5'd0, 5'd0, 4'd0, 4'd0));
        expect_cfg("t5_slot6_ssg", 6, pk(1'b0, 1'b1, 3'd5, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 4'd0, 4'd0));
        drain();

        // write slot 2 on the edge that presents it: old now, new one frame later
        wait_slot1("t6");
        cq.push_back('{"t6_old", 2, cyc + 1, pk(1'b0, 1'b0, 3'd0, 7'd0, 2'd2, 5'd31, 5'd0, 5'd0, 4'd0, 4'd0)});
        cq.push_back('{"t6_new", 2, cyc + 2, pk(1'b0, 1'b0, 3'd0, 7'd0, 2'd2, 5'd31, 5'd21, 5'd0, 4'd0, 4'd0)});
        ack_q.push_back(-1);
        wr_part = 1'b0;
        wr_addr = 8'h62;
        wr_data = 8'h15;
        wr_req  = 1'b1;
        wait_ack("t6");
        wr_req = 1'b0;
        wait_idle("t6");
        drain();

        // reset in the middle of a write's busy phase
        ack_q.push_back(-1);
        wr_addr = 8'h41;
        wr_data = 8'h11;
        wr_req  = 1'b1;
        wait_ack("t7");
        wr_req = 1'b0;
        repeat (5) @(negedge clk);
        track = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst2_cfg", 64'(cfg_now()), 64'(Z));
        chk("rst2_slot", 64'(slot), 64'(0));
        chk("rst2_zero", 64'(zero), 64'(1));
        chk("rst2_busy", 64'(busy), 64'(0));
        chk("rst2_ack", 64'(wr_ack), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_slot1("rst2");
        track = 1'b1;
        expect_cfg("rst2_slot1", 1, Z);
        expect_cfg("rst2_slot2", 2, Z);
        expect_cfg("rst2_slot6", 6, Z);
        expect_cfg("rst2_slot15", 15, Z);
        drain();
        repeat (40) @(negedge clk);
        chk("rst2_busy_idle", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        fail("watchdog", cyc, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
